// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Program-load sequencer between a UART byte receiver and the core's program
//   memory. Parses a frame of LEN[7:0], LEN[15:8] and LEN payload bytes, then
//   writes the payload to program memory from address 0 upward. The core is
//   held in reset until a load completes successfully.
//
//   Optional feature macro: PROG_LOADER_CHECKSUM_EN
//     When defined, a trailing CHK byte must equal the XOR of all payload bytes.
//
// Parameters
//   AW        program memory address width (DEPTH = 2**AW bytes)
//   TIMEOUT   max clk cycles allowed between bytes once a load has started
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   rx_data    in   [7:0]  received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   load_req   in   one-cycle strobe, aborts/restarts a load (wins over rx_valid)
//   mem_we     out  program memory write enable pulse
//   mem_addr   out  [AW-1:0] write address (holds between writes)
//   mem_wdata  out  [7:0]    write data
//   cpu_rst    out  active-high core reset, low only after a successful load
//   loading    out  high while a frame is being received after LEN[7:0]
//   done       out  load completed successfully
//   err        out  load failed (oversize, timeout or checksum)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          load_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          cpu_rst,
    output logic          loading,
    output logic          done,
    output logic          err
);

    localparam int          DEPTH    = 2 ** AW;
    localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [16:0] DEPTH_L  = 17'(DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHK    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d;
    // One bit wider than a full memory so a DEPTH-byte payload reaches len
    // without wrapping before the compare.
    logic [16:0]     count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            loading_q, loading_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     len_full_s;
    logic [16:0]     count_inc_s;
    logic            timed_s;
    logic            tmo_hit_s;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]      xor_q, xor_d;
`endif

    assign len_full_s  = {rx_data, len_q[7:0]};
    assign count_inc_s = count_q + 17'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign timed_s     = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CHK);
`else
    assign timed_s     = (state_q == S_LEN_HI) || (state_q == S_DATA);
`endif
    assign tmo_hit_s   = timed_s && !rx_valid && (tmo_q == TMO_LAST);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        if (load_req) begin
            // Restart wins over a coincident byte, which is dropped.
            state_d = S_LEN_LO;
            len_d   = 16'd0;
            count_d = 17'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_d   = 8'd0;
`endif
        end else if (tmo_hit_s) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_LEN_LO: begin
                    if (rx_valid) begin
                        len_d   = {8'd0, rx_data};
                        state_d = S_LEN_HI;
                    end else begin
                        state_d = S_LEN_LO;
                    end
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        len_d   = len_full_s;
                        count_d = 17'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_d   = 8'd0;
`endif
                        if (len_full_s == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end else if ({1'b0, len_full_s} > DEPTH_L) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_LEN_HI;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q[AW-1:0];
                        mem_wdata_d = rx_data;
                        count_d     = count_inc_s;
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_d       = xor_q ^ rx_data;
`endif
                        if (count_inc_s == {1'b0, len_q}) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == xor_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        state_d = S_CHK;
                    end
                end
`endif
                S_DONE:  state_d = S_DONE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_ERR;
            endcase
        end

        // Timeout counter restarts on every byte, on every state change and
        // outside the timed states.
        if (load_req || rx_valid || !timed_s || (state_d != state_q)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        // Status outputs are registered images of the next state.
        cpu_rst_d = (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
`ifdef PROG_LOADER_CHECKSUM_EN
        loading_d = (state_d == S_LEN_HI) || (state_d == S_DATA) || (state_d == S_CHK);
`else
        loading_d = (state_d == S_LEN_HI) || (state_d == S_DATA);
`endif
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LEN_LO;
            len_q       <= 16'd0;
            count_q     <= 17'd0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            cpu_rst_q   <= 1'b1;
            loading_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            loading_q   <= loading_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign loading   = loading_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Scoreboard bench for prog_loader. Stimulus tasks build frames, push the
//   expected memory writes (address/data) into a queue, and a separate monitor
//   pops and compares on every mem_we pulse. Frame outcomes (done/err) are
//   derived from the frame contents with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int AW      = 8;
    localparam int DEPTH   = 2 ** AW;
    localparam int TIMEOUT = 100;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CHK_EN  = 1'b1;
`else
    localparam bit CHK_EN  = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          load_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_rst;
    logic          loading;
    logic          done;
    logic          err;

    int            cmp_cnt = 0;
    int            mis_cnt = 0;
    logic [15:0]   exp_q[$];       // {addr, data} of expected writes
    logic [7:0]    payload[$];

    prog_loader #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .load_req  (load_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .loading   (loading),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected write addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("write addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                chk("write data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int gap_max);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
    endtask

    task automatic check_status(input string name, input bit exp_done, input bit exp_err, input bit exp_loading);
        chk({name, " done"},    {31'd0, done},    {31'd0, exp_done});
        chk({name, " err"},     {31'd0, err},     {31'd0, exp_err});
        chk({name, " cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !exp_done});
        chk({name, " loading"}, {31'd0, loading}, {31'd0, exp_loading});
    endtask

    task automatic restart();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check_status("restart", 1'b0, 1'b0, 1'b0);
    endtask

    // Sends LEN, the payload queue (or junk when oversize) and, with the
    // option, a CHK byte; checks the outcome right after the deciding byte.
    task automatic run_frame(input int len, input bit bad_chk, input int gap_max);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] l16;
        bit ovs;
        bit ok;
        l16 = len[15:0];
        x   = 8'd0;
        ovs = (len > DEPTH);
        ok  = !ovs && !(CHK_EN && bad_chk);
        restart();
        send_byte(l16[7:0]);
        chk("loading after LEN lo", {31'd0, loading}, 32'd1);
        idle(gap_max);
        send_byte(l16[15:8]);
        if (!ovs) begin
            for (int i = 0; i < len; i++) begin
                idle(gap_max);
                b = payload[i];
                exp_q.push_back({i[7:0], b});
                x = x ^ b;
                send_byte(b);
            end
            if (CHK_EN) begin
                idle(gap_max);
                send_byte(bad_chk ? (x ^ 8'h5A) : x);
            end
        end
        check_status(ok ? "frame done" : "frame err", ok, !ok, 1'b0);
        // Bytes after the frame end must be ignored.
        send_byte(8'hEE);
        send_byte(8'h3C);
        @(negedge clk);
        chk("pending writes", exp_q.size(), 32'd0);
        check_status("frame hold", ok, !ok, 1'b0);
    endtask

    task automatic fill_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int r;
        rst      = 1'b0;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        check_status("reset", 1'b0, 1'b0, 1'b0);
        chk("reset mem_we",    {31'd0, mem_we},    32'd0);
        chk("reset mem_addr",  {24'd0, mem_addr},  32'd0);
        chk("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic load.
        payload = '{8'hA1, 8'hB2, 8'hC3};
        run_frame(3, 1'b0, 0);
        // Zero length.
        payload.delete();
        run_frame(0, 1'b0, 2);
        // Oversize by one and a full-memory load.
        run_frame(257, 1'b0, 1);
        fill_payload(256);
        run_frame(256, 1'b0, 1);

        // Timeout after one payload byte.
        restart();
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back({8'h00, 8'h55});
        send_byte(8'h55);
        n = 0;
        while (!err && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout cycles", n, TIMEOUT);
        check_status("timeout", 1'b0, 1'b1, 1'b0);
        chk("timeout pending", exp_q.size(), 32'd0);
        restart();

        // Restart colliding with a byte while in DONE.
        payload = '{8'h10};
        run_frame(1, 1'b0, 0);
        load_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h07;
        @(negedge clk);
        load_req = 1'b0;
        rx_valid = 1'b0;
        check_status("collision", 1'b0, 1'b0, 1'b0);
        send_byte(8'h01);
        send_byte(8'h00);
        exp_q.push_back({8'h00, 8'h99});
        send_byte(8'h99);
        if (CHK_EN) send_byte(8'h99);
        check_status("after collision", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("collision pending", exp_q.size(), 32'd0);

        // Async reset between payload bytes.
        restart();
        send_byte(8'h04);
        send_byte(8'h00);
        exp_q.push_back({8'h00, 8'h11});
        send_byte(8'h11);
        #1 rst = 1'b0;
        #1;
        check_status("async reset", 1'b0, 1'b0, 1'b0);
        chk("async mem_we",   {31'd0, mem_we},   32'd0);
        chk("async mem_addr", {24'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("async pending", exp_q.size(), 32'd0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       len = 0;
                1:       len = 256;
                2:       len = $urandom_range(257, 65535);
                default: len = $urandom_range(1, 24);
            endcase
            fill_payload((len > DEPTH) ? 0 : len);
            run_frame(len, ($urandom_range(0, 3) == 0), (r == 3) ? 90 : 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- UART program-load sequencer that sits between the UART byte receiver and the core's program memory.
- Parses a length-prefixed byte stream and writes the payload to program memory from address 0 upward.
- Holds the core in reset while loading; releases it on successful completion.
- Flags protocol errors: oversize length, inter-byte timeout and, optionally, checksum mismatch.

Parameters:
- AW, 8: program memory address width; DEPTH = 2**AW bytes.
- TIMEOUT, 1_000_000: max clk cycles allowed between consecutive bytes once a load has started.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- load_req  in  1  one-cycle strobe; aborts or restarts a load.
- mem_we  out  1  program memory write enable, one-cycle pulse.
- mem_addr  out  AW  program memory write address.
- mem_wdata  out  8  program memory write data.
- cpu_rst  out  1  active-high reset to the core.
- loading  out  1  high in LEN_HI, DATA and CHK.
- done  out  1  load completed successfully.
- err  out  1  load failed.

Behaviour:
- Reset (rst low, async):
  - state = LEN_LO; mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - cpu_rst = 1; loading = 0; done = 0; err = 0.
  - len, byte count and timeout counter = 0.
- Frame format: LEN[7:0], LEN[15:8], then LEN payload bytes; CHK byte follows only with the option enabled.
- LEN_LO:
  - On rx_valid: len[7:0] = rx_data; go to LEN_HI.
  - No timeout runs in this state.
- LEN_HI:
  - On rx_valid: len[15:8] = rx_data.
  - Full 16-bit len == 0: go to DONE, or to CHK if the option is enabled.
  - len > DEPTH: go to ERR.
  - Otherwise: go to DATA with count = 0.
- DATA:
  - On rx_valid: next cycle mem_we = 1, mem_addr = count, mem_wdata = rx_data (latency 1 clk); count += 1.
  - When count reaches len: go to DONE, or to CHK if the option is enabled.
  - mem_addr holds its last value between writes.
- Timeout:
  - The counter runs in LEN_HI, DATA and CHK.
  - It clears on every rx_valid and on entry to each of those states.
  - Reaching TIMEOUT-1 without rx_valid: go to ERR on the next edge.
- DONE: cpu_rst = 0; done = 1; rx_valid is ignored.
- ERR: cpu_rst = 1; err = 1; rx_valid is ignored. mem_we never pulses after the erroring byte.
- load_req, in any state:
  - Next state LEN_LO; count, len and timeout cleared.
  - cpu_rst = 1; done = 0; err = 0.
  - If rx_valid arrives in the same cycle, load_req wins and the byte is dropped with no write.
- Exclusivity: done and err are never high together. cpu_rst is low only in DONE.
- A payload of exactly DEPTH bytes is legal. The last write goes to address DEPTH-1, and count must not wrap before the compare.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes is kept; it starts at 0 on entry to DATA.
  - After the payload, state CHK waits for one byte, with the timeout active.
  - CHK byte == XOR: go to DONE. Otherwise: go to ERR.
  - With len == 0 the expected CHK byte is 0x00.
- Not defined:
  - No CHK state and no XOR register.
  - DATA, or LEN_HI with len == 0, goes directly to DONE.

Test Plan:
- Basic load:
  - Stimulus: reset, then send 0x03, 0x00, 0xA1, 0xB2, 0xC3 (with the option: append CHK 0xD0).
  - Response: three mem_we pulses with addr/data 0/A1, 1/B2, 2/C3. Then done = 1, cpu_rst = 0, err = 0.
- Zero length:
  - Stimulus: send 0x00, 0x00 (with the option: 0x00, 0x00, 0x00).
  - Response: no mem_we; done = 1 within 1 clk of the final rx_valid.
- Oversize:
  - Stimulus: AW = 8; send 0x01, 0x01 (len = 257).
  - Response: err = 1, cpu_rst = 1, no mem_we. A full 256-byte load also completes with a last write to addr 0xFF.
- Timeout:
  - Stimulus: TIMEOUT = 100; send 0x02, 0x00, 0x55, then idle.
  - Response: one write (0/55), then err = 1 about 100 clk after the 0x55. A later load_req gives LEN_LO with err = 0.
- Restart and collision:
  - Stimulus: in DONE, assert load_req together with rx_valid carrying 0x07.
  - Response: done = 0, cpu_rst = 1, byte dropped. A following 0x01, 0x00, 0x99 writes 0/99 and finishes with done = 1.
- Async reset mid-DATA:
  - Stimulus: drop rst between payload bytes.
  - Response: outputs take their reset values immediately, without waiting for clk. With the option: a wrong CHK byte gives err = 1.
